// File: rtl/fpmod_arbiter.sv
// Round-robin arbiter that shares one fpmod remainder unit among NREQ requesters.
// Optional watchdog: define FPMOD_ARB_TIMEOUT_EN to bound the wait for fm_done.
module fpmod_arbiter #(
    parameter int N       = 32,
    parameter int Q       = 16,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*N-1:0]   req_in1,
    input  logic [NREQ*N-1:0]   req_in2,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic [N-1:0]        result,
    output logic                busy,
    output logic                fm_start,
    output logic [N-1:0]        fm_in1,
    output logic [N-1:0]        fm_in2,
    input  logic [N-1:0]        fm_rem,
    input  logic                fm_done,
    output logic                err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Q only describes the operand format; the arbiter never looks inside a word.
    if (Q < 0 || Q >= N || NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("fpmod_arbiter: parameter out of range");
    end

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic [PW-1:0] pick;
    logic          pick_vld;
    int            scan_idx;

`ifdef FPMOD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;
    logic          err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy = (state != IDLE);

    // First requester at or above the pointer, wrapping back to 0.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(ptr) + k) % NREQ;
            if (!pick_vld && req[scan_idx]) begin
                pick_vld = 1'b1;
                pick     = PW'(scan_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            done     <= '0;
            fm_start <= 1'b0;
            result   <= '0;
            fm_in1   <= '0;
            fm_in2   <= '0;
            ptr      <= '0;
            winner   <= '0;
`ifdef FPMOD_ARB_TIMEOUT_EN
            wd_cnt   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            done     <= '0;
            fm_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        winner   <= pick;
                        grant    <= NREQ'(1) << pick;
                        fm_in1   <= req_in1[int'(pick)*N +: N];
                        fm_in2   <= req_in2[int'(pick)*N +: N];
                        fm_start <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef FPMOD_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                WAIT: begin
                    // Only a completion seen here belongs to the operation in flight.
                    if (fm_done) begin
                        result <= fm_rem;
                        done   <= grant;
                        state  <= RESP;
                    end
`ifdef FPMOD_ARB_TIMEOUT_EN
                    else if (wd_cnt == TW'(TIMEOUT - 1)) begin
                        result <= '0;
                        err_q  <= 1'b1;
                        done   <= grant;
                        state  <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    grant <= '0;
                    ptr   <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmod_arbiter.sv
// Directed bench for fpmod_arbiter with an fpmod stub and a result scoreboard.
module tb_fpmod_arbiter;
    localparam int N    = 32;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*N-1:0] req_in1 = '0;
    logic [NREQ*N-1:0] req_in2 = '0;
    logic [NREQ-1:0]   grant, done;
    logic [N-1:0]      result, fm_in1, fm_in2, fm_rem;
    logic              busy, fm_start, fm_done, err;

    fpmod_arbiter #(.N(N), .Q(16), .NREQ(NREQ), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_in1(req_in1), .req_in2(req_in2),
        .grant(grant), .done(done), .result(result), .busy(busy),
        .fm_start(fm_start), .fm_in1(fm_in1), .fm_in2(fm_in2),
        .fm_rem(fm_rem), .fm_done(fm_done), .err(err)
    );

    always #5 clk = ~clk;

    // fpmod stub: fm_done L cycles after the start pulse, remainder of raw words.
    int           stub_lat  = 6;
    bit           stub_hang = 1'b0;
    int           stub_cnt  = 0;
    logic         stub_done = 1'b0;
    logic [N-1:0] stub_rem  = '0;
    logic         stale     = 1'b0;
    logic         s_start, s_rst;
    logic [N-1:0] s_a, s_b;

    assign fm_done = stub_done | stale;
    assign fm_rem  = stale ? 32'hDEAD_BEEF : stub_rem;

    always @(posedge clk) begin
        s_start = fm_start;
        s_rst   = rst;
        s_a     = fm_in1;
        s_b     = fm_in2;
        #1;
        stub_done = 1'b0;
        if (!s_rst) begin
            stub_cnt = 0;
        end else if (s_start) begin
            stub_cnt = stub_hang ? 0 : stub_lat - 1;
            stub_rem = (s_b != 0) ? s_a % s_b : '0;
        end else if (stub_cnt != 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) stub_done = 1'b1;
        end
    end

    typedef struct {
        int           idx;
        logic [N-1:0] res;
    } exp_t;

    exp_t            sb[$];
    logic [N-1:0]    op1[NREQ];
    logic [N-1:0]    op2[NREQ];
    logic [NREQ-1:0] keep = '0;
    int              checks = 0;
    int              errors = 0;
    int              start_cnt = 0;
    int              el;
    logic [N-1:0]    prev_res;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input int i);
        return (op2[i] != 0) ? op1[i] % op2[i] : '0;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_in1[i*N +: N] = op1[i];
            req_in2[i*N +: N] = op2[i];
        end
    endtask

    task automatic push_exp(input int i, input logic [N-1:0] r);
        exp_t e;
        e.idx = i;
        e.res = r;
        sb.push_back(e);
    endtask

    // Collects n completions against the scoreboard; requesters drop req on done.
    task automatic wait_ops(input int n, input int budget, output int elapsed);
        int   seen;
        exp_t e;
        seen    = 0;
        elapsed = 0;
        while (seen < n && elapsed < budget) begin
            @(negedge clk);
            elapsed++;
            if (done != 0) begin
                seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", N'(done), '0);
                end else begin
                    e = sb.pop_front();
                    chk("done_onehot", N'(done), N'(NREQ'(1) << e.idx));
                    chk("result", result, e.res);
                end
                req = req & ~(done & ~keep);
                if (seen == n) req = '0;
            end
        end
        chk("ops_completed", N'(seen), N'(n));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", N'(grant), '0);
        chk("rst_done", N'(done), '0);
        chk("rst_fm_start", N'(fm_start), '0);
        chk("rst_busy", N'(busy), '0);
        chk("rst_err", N'(err), '0);
        chk("rst_result", result, '0);
        chk("rst_fm_in1", fm_in1, '0);
        chk("rst_fm_in2", fm_in2, '0);
        rst = 1'b1;
        start_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            assert ($onehot0(grant)) else begin
                errors++;
                $error("FAIL grant_onehot observed=%b expected=one-hot or zero", grant);
            end
            checks++;
            assert ((done & ~grant) == 0) else begin
                errors++;
                $error("FAIL done_within_grant observed=%b expected_subset_of=%b", done, grant);
            end
            if (fm_start) start_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            op1[i] = 32'h0005_8000 + 32'h0001_3579 * i;
            op2[i] = 32'h0002_0000 + 32'h0000_4000 * i;
        end
        pack_ops();
        do_reset();

        // Single request, latency 6: 5.5 mod 2.0 = 1.5
        @(negedge clk);
        req = 4'b0001;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("t1_fm_start_c%0d", k), N'(fm_start), N'(k == 1));
            chk($sformatf("t1_grant_c%0d", k), N'(grant), (k <= 8) ? N'(1) : '0);
            chk($sformatf("t1_busy_c%0d", k), N'(busy), N'(k <= 8));
            chk($sformatf("t1_done_c%0d", k), N'(done), (k == 8) ? N'(1) : '0);
            if (k == 4) begin
                chk("t1_fm_in1_held", fm_in1, 32'h0005_8000);
                chk("t1_fm_in2_held", fm_in2, 32'h0002_0000);
            end
            if (k == 8) begin
                chk("t1_result", result, 32'h0001_8000);
                req = '0;
            end
        end
        chk("t1_result_held", result, 32'h0001_8000);

        // All four at once after reset: grants 0,1,2,3
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) push_exp(i, model(i));
        req = 4'b1111;
        wait_ops(4, 200, el);
        chk("t2_start_count", N'(start_cnt), N'(4));

        // Fairness with 0 and 2 held permanently high
        @(negedge clk);
        keep = 4'b0101;
        push_exp(0, model(0)); push_exp(2, model(2));
        push_exp(0, model(0)); push_exp(2, model(2));
        req = 4'b0101;
        wait_ops(4, 200, el);
        keep = '0;

        // Reset in the third WAIT cycle aborts without done
        stub_lat = 20;
        @(negedge clk);
        req = 4'b0010;
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            chk("t4_no_done_before_rst", N'(done), '0);
        end
        rst = 1'b0;
        req = '0;
        @(posedge clk);
        @(negedge clk);
        chk("t4_grant_after_rst", N'(grant), '0);
        chk("t4_busy_after_rst", N'(busy), '0);
        chk("t4_done_after_rst", N'(done), '0);
        chk("t4_start_after_rst", N'(fm_start), '0);
        rst = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            chk("t4_no_done_idle", N'(done), '0);
        end
        // Pointer back at 0: requester 1 wins over 3
        stub_lat = 6;
        push_exp(1, model(1));
        push_exp(3, model(3));
        req = 4'b1010;
        wait_ops(2, 100, el);

        // Stale fm_done in IDLE and ISSUE
        @(negedge clk);
        prev_res = result;
        stale = 1'b1;
        @(negedge clk);
        chk("t5_idle_stale_done", N'(done), '0);
        stale = 1'b0;
        @(negedge clk);
        chk("t5_idle_stale_done2", N'(done), '0);
        chk("t5_idle_stale_busy", N'(busy), '0);
        chk("t5_idle_stale_result", result, prev_res);
        push_exp(0, model(0));
        req = 4'b0001;
        @(posedge clk);
        #1 stale = 1'b1;
        @(posedge clk);
        #1 stale = 1'b0;
        wait_ops(1, 100, el);
        chk("t5_real_done_time", N'(el), N'(7));

`ifdef FPMOD_ARB_TIMEOUT_EN
        // Stub never answers: watchdog forces completion with result 0
        stub_hang = 1'b1;
        @(negedge clk);
        push_exp(2, '0);
        req = 4'b0100;
        @(posedge clk);
        wait_ops(1, 200, el);
        chk("t6_timeout_done_time", N'(el), N'(66));
        chk("t6_err_set", N'(err), N'(1));
        stub_hang = 1'b0;
        @(negedge clk);
        push_exp(3, model(3));
        req = 4'b1000;
        wait_ops(1, 100, el);
        chk("t6_err_sticky", N'(err), N'(1));
`else
        chk("err_tied_low", N'(err), '0);
`endif

        chk("sb_drained", N'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpmod_arbiter.md
Name: fpmod_arbiter

Overview:
- Shares one fpmod (fixed-point remainder, S-E-M 1-15-16 format) unit among NREQ requesters in the CODEC2_ENCODE_2400 datapath. Typical requesters: cossin_cordic phase wrap and pitch/LSP angle reduction.
- Uses round-robin arbitration and a start/done handshake to each requester.
- Owns the fpmod start/operand lines and holds operands stable for the whole operation.

Parameters:
- N, 32, data word width (bits)
- Q, 16, fractional bits; pass-through only, the arbiter does no arithmetic
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 64, watchdog limit in cycles; used only when FPMOD_ARB_TIMEOUT_EN is defined

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- req  in  NREQ  request level, one bit per requester
- req_in1  in  NREQ*N  dividend per requester; slice i = [i*N +: N]
- req_in2  in  NREQ*N  divisor per requester, same slicing
- grant  out  NREQ  one-hot; high from arbitration until that requester's done
- done  out  NREQ  one-cycle completion pulse to the granted requester
- result  out  N  last remainder; valid in the done cycle and held until the next completion
- busy  out  1  high in any state other than IDLE
- fm_start  out  1  drives fpmod startfmod
- fm_in1  out  N  drives fpmod in_1
- fm_in2  out  N  drives fpmod in_2
- fm_rem  in  N  from fpmod rem
- fm_done  in  1  from fpmod donefmod
- err  out  1  timeout flag; tied 0 when the macro is absent

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE.
  - grant, done, fm_start, busy, err = 0.
  - result, fm_in1, fm_in2 = 0.
  - RR pointer = 0.
- Reset mid-operation: abort immediately to IDLE. No done is issued. fpmod shares rst and restarts too.
- State IDLE:
  - If req != 0, select the winner = first set bit scanning upward from the pointer, wrapping at NREQ-1 to 0.
  - Latch fm_in1/fm_in2 from the winner's slices, set grant[winner], go to ISSUE.
  - If no request, stay in IDLE.
- State ISSUE: fm_start=1 for exactly this one cycle, then go to WAIT.
- State WAIT:
  - fm_start=0.
  - When fm_done=1, register result<=fm_rem and go to RESP.
  - fm_in1/fm_in2 are held unchanged throughout WAIT.
- State RESP:
  - done[winner]=1 for this one cycle; grant clears at the end of the cycle.
  - pointer <= (winner+1) mod NREQ.
  - Go to IDLE.
- fm_done seen in IDLE, ISSUE or RESP is ignored. A stale pulse must not complete a new operation.
- Latency (req sampled in IDLE at cycle 0):
  - fm_start at cycle 1.
  - If fpmod raises fm_done L cycles after start, done is at cycle 2+L.
  - Minimum issue spacing between back-to-back operations is 3+L cycles.
- Requester rules:
  - Hold req and operands stable until done.
  - Drop req in the cycle after done. A req still high when IDLE samples it counts as a new request.
  - Dropping req while granted does not abort; the operation completes and done still pulses.
- Simultaneous requests: exactly one grant per arbitration. No requester waits more than NREQ-1 operations.
- Only one operation is in flight at any time; grant is never multi-hot.

Optional Feature:
- Macro FPMOD_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without fm_done: set err=1 (sticky until reset), set result=0, go to RESP (done still pulses, pointer still advances).
- Undefined:
  - No counter; WAIT waits indefinitely.
  - err is constant 0.

Test Plan:
- Single request, fpmod stub latency L=6: req[0]=1, in1=0x00058000 (5.5), in2=0x00020000 (2.0), stub returns 0x00018000 -> fm_start pulses at cycle 1, done[0] at cycle 8, result=0x00018000, grant=0001 until done.
- All four requesting at once after reset -> grants in order 0,1,2,3. Each done pulses once with its own stub result. fm_start count = 4, grant always one-hot.
- Round-robin fairness: req[0] and req[2] held permanently high -> grant sequence 0,2,0,2. Requesters 1 and 3 are never granted.
- Reset mid-operation: assert rst=0 at WAIT cycle 3 -> next cycle grant=0, busy=0, done never pulses, pointer=0. A following req[3] is granted normally.
- Stale fm_done: stub pulses fm_done while IDLE and during ISSUE -> no done pulse and result unchanged. The real completion is still taken.
- With FPMOD_ARB_TIMEOUT_EN, TIMEOUT=64: stub never raises fm_done -> done pulses 64 WAIT cycles later, err=1, result=0. A next request completes normally with err still 1.
